lockstep_commit_scheduler: RTL

Lockstep scheduler for the two-copy Sodor 2-stage sandbox. It owns the per-copy clock enables and re-aligns the copies whenever their commit streams skew. It records commit-data and memory-address deviations as sticky flags, then sequences both copies through drain into a terminal halt. It sits in the sandbox top between the two `SodorInternalTile` instances and the property/assumption logic.

---
 rtl/lockstep_commit_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lockstep_commit_scheduler.sv
// Lockstep scheduler for the two-copy sandbox: gates per-copy clock enables, re-aligns skewed
// commit streams, records sticky deviation flags and drains both copies into a terminal halt.
module lockstep_commit_scheduler #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SKEW_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid_1,
    input  logic              commit_valid_2,
    input  logic [DATA_W-1:0] commit_data_1,
    input  logic [DATA_W-1:0] commit_data_2,
    input  logic              mem_valid_1,
    input  logic              mem_valid_2,
    input  logic [ADDR_W-1:0] mem_addr_1,
    input  logic [ADDR_W-1:0] mem_addr_2,
    output logic              en_1,
    output logic              en_2,
    output logic              commit_deviation,
    output logic              addr_deviation,
    output logic              invalid_program,
    output logic              skew_timeout,
    output logic              finish_1,
    output logic              finish_2,
    output logic              done,
    output logic [1:0]        state
);

    localparam int unsigned CNT_W = (SKEW_MAX > 0) ? $clog2(SKEW_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKEW_MAX);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StWait1 = 2'd1,
        StWait2 = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              cdev_q, cdev_d;
    logic              adev_q, adev_d;
    logic              inv_q, inv_d;
    logic              tout_q, tout_d;
    logic              fin1_q, fin1_d;
    logic              fin2_q, fin2_d;

    logic [ADDR_W-1:0] eaddr_1, eaddr_2;
    logic              c1, c2, halt_go;

    assign eaddr_1 = mem_valid_1 ? mem_addr_1 : '0;
    assign eaddr_2 = mem_valid_2 ? mem_addr_2 : '0;

    // Enables are decoded from registered state only.
    assign en_1 = (state_q == StRun) || (state_q == StWait2);
    assign en_2 = (state_q == StRun) || (state_q == StWait1);

    // A frozen copy's commit_valid is meaningless and must be ignored.
    assign c1      = commit_valid_1 & en_1;
    assign c2      = commit_valid_2 & en_2;
    assign halt_go = fin1_q & fin2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            hold_q  <= '0;
            cdev_q  <= 1'b0;
            adev_q  <= 1'b0;
            inv_q   <= 1'b0;
            tout_q  <= 1'b0;
            fin1_q  <= 1'b0;
            fin2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            cdev_q  <= cdev_d;
            adev_q  <= adev_d;
            inv_q   <= inv_d;
            tout_q  <= tout_d;
            fin1_q  <= fin1_d;
            fin2_q  <= fin2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        cdev_d  = cdev_q;
        adev_d  = adev_q;
        inv_d   = inv_q;
        tout_d  = tout_q;
        fin1_d  = fin1_q;
        fin2_d  = fin2_q;

        if (state_q != StHalt) begin
            if (!cdev_q && (eaddr_1 != eaddr_2)) begin
                adev_d = 1'b1;
            end
            if (cdev_q || adev_q) begin
                if (c1) fin1_d = 1'b1;
                if (c2) fin2_d = 1'b1;
            end
        end

        unique case (state_q)
            StRun: begin
                if (c1 && c2) begin
                    if (commit_data_1 != commit_data_2) inv_d = 1'b1;
                end else if (c1) begin
                    cdev_d  = 1'b1;
                    hold_d  = commit_data_1;
                    cnt_d   = '0;
                    state_d = StWait1;
                end else if (c2) begin
                    cdev_d  = 1'b1;
                    hold_d  = commit_data_2;
                    cnt_d   = '0;
                    state_d = StWait2;
                end
            end
            StWait1: begin
                if (c2) begin
                    if (hold_q != commit_data_2) inv_d = 1'b1;
                    state_d = StRun;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    tout_d  = 1'b1;
                    state_d = StHalt;
                end
            end
            StWait2: begin
                if (c1) begin
                    if (hold_q != commit_data_1) inv_d = 1'b1;
                    state_d = StRun;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    tout_d  = 1'b1;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase

        // Drain completion overrides any transition; hold only loads on a real RUN->WAIT move.
        if (halt_go) begin
            state_d = StHalt;
            hold_d  = hold_q;
        end
    end

    assign commit_deviation = cdev_q;
    assign addr_deviation   = adev_q;
    assign invalid_program  = inv_q;
    assign skew_timeout     = tout_q;
    assign finish_1         = fin1_q;
    assign finish_2         = fin2_q;
    assign done             = (state_q == StHalt);
    assign state            = state_q;

endmodule
